// File: rtl/keypad_entry.sv
// Keypad entry front end: synchronizes scanner keys, debounces them into single events,
// and assembles two decimal operands plus an add/subtract operator for the calculator core.
module keypad_entry #(
  parameter int unsigned W           = 8,
  parameter int unsigned MAX_DIGITS  = 3,
  parameter int unsigned RELEASE_CYC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   value,
  input  logic         valid,
  output logic [W-1:0] operand_a,
  output logic [W-1:0] operand_b,
  output logic         op,
  output logic         go,
  output logic         err,
  output logic [W-1:0] disp_value,
  output logic [1:0]   state_o
);

  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);
  localparam int unsigned RelW = $clog2(RELEASE_CYC + 1);
  localparam int unsigned AccW = W + 4;

  localparam logic [3:0] KeyAdd   = 4'd10;
  localparam logic [3:0] KeySub   = 4'd11;
  localparam logic [3:0] KeyClear = 4'd12;
  localparam logic [3:0] KeyEq    = 4'd13;

  localparam logic [AccW-1:0] MaxVal = AccW'({W{1'b1}});

  typedef enum logic [1:0] {
    StEntryA = 2'd0,
    StEntryB = 2'd1,
    StReady  = 2'd2
  } state_e;

  // Synchronizers, edge detect and re-arm tracking
  logic [3:0]      value_s1, value_s2;
  logic            valid_s1, valid_s2, valid_prev;
  logic            armed_q, armed_d;
  logic [RelW-1:0] rel_cnt_q, rel_cnt_d;
  logic            key_evt;
  logic            evt_q;
  logic [3:0]      key_q;

  // Entry state
  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [CntW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic            op_q, op_d, go_q, go_d, err_q, err_d;

  // Digit accumulate helpers
  logic [AccW-1:0] acc_sel, acc_new;
  logic [CntW-1:0] cnt_sel;
  logic            digit_ok, is_digit, is_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_s1   <= 4'd0;
      value_s2   <= 4'd0;
      valid_s1   <= 1'b0;
      valid_s2   <= 1'b0;
      valid_prev <= 1'b0;
    end else begin
      value_s1   <= value;
      value_s2   <= value_s1;
      valid_s1   <= valid;
      valid_s2   <= valid_s1;
      valid_prev <= valid_s2;
    end
  end

  assign key_evt = valid_s2 & ~valid_prev & armed_q;

  // Re-arm only after synced valid has stayed low for RELEASE_CYC cycles in a row.
  always_comb begin
    armed_d   = armed_q;
    rel_cnt_d = rel_cnt_q;
    if (key_evt) begin
      armed_d   = 1'b0;
      rel_cnt_d = '0;
    end else if (!armed_q) begin
      if (valid_s2) begin
        rel_cnt_d = '0;
      end else if (rel_cnt_q == RelW'(RELEASE_CYC - 1)) begin
        armed_d   = 1'b1;
        rel_cnt_d = '0;
      end else begin
        rel_cnt_d = rel_cnt_q + RelW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q   <= 1'b1;
      rel_cnt_q <= '0;
      evt_q     <= 1'b0;
      key_q     <= 4'd0;
    end else begin
      armed_q   <= armed_d;
      rel_cnt_q <= rel_cnt_d;
      evt_q     <= key_evt;
      key_q     <= value_s2;
    end
  end

  always_comb begin
    is_digit = (key_q <= 4'd9);
    is_op    = (key_q == KeyAdd) || (key_q == KeySub);
    acc_sel  = (state_q == StEntryA) ? AccW'(a_q) : AccW'(b_q);
    cnt_sel  = (state_q == StEntryA) ? cnt_a_q : cnt_b_q;
    acc_new  = acc_sel * AccW'(10) + AccW'(key_q);
    digit_ok = (cnt_sel != CntW'(MAX_DIGITS)) && (acc_new <= MaxVal);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    op_d    = op_q;
    err_d   = err_q;
    go_d    = 1'b0;

    if (evt_q) begin
      if (key_q == KeyClear) begin
        state_d = StEntryA;
        a_d     = '0;
        b_d     = '0;
        cnt_a_d = '0;
        cnt_b_d = '0;
        op_d    = 1'b0;
        err_d   = 1'b0;
      end else begin
        unique case (state_q)
          StEntryA: begin
            if (is_digit) begin
              if (digit_ok) begin
                a_d     = acc_new[W-1:0];
                cnt_a_d = cnt_a_q + CntW'(1);
              end else begin
                err_d = 1'b1;
              end
            end else if (is_op) begin
              if (cnt_a_q != '0) begin
                op_d    = (key_q == KeySub);
                b_d     = '0;
                cnt_b_d = '0;
                err_d   = 1'b0;
                state_d = StEntryB;
              end else begin
                err_d = 1'b1;
              end
            end else if (key_q == KeyEq) begin
              err_d = 1'b1;
            end
          end
          StEntryB: begin
            if (is_digit) begin
              if (digit_ok) begin
                b_d     = acc_new[W-1:0];
                cnt_b_d = cnt_b_q + CntW'(1);
              end else begin
                err_d = 1'b1;
              end
            end else if (is_op) begin
              op_d = (key_q == KeySub);
            end else if (key_q == KeyEq) begin
              if (cnt_b_q != '0) begin
                go_d    = 1'b1;
                state_d = StReady;
              end else begin
                err_d = 1'b1;
              end
            end
          end
          StReady: begin
            if (is_digit) begin
              a_d     = W'(key_q);
              cnt_a_d = CntW'(1);
              b_d     = '0;
              cnt_b_d = '0;
              state_d = StEntryA;
            end else if (is_op) begin
              op_d    = (key_q == KeySub);
              b_d     = '0;
              cnt_b_d = '0;
              err_d   = 1'b0;
              state_d = StEntryB;
            end else if (key_q == KeyEq) begin
              go_d = 1'b1;
            end
          end
          default: state_d = StEntryA;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEntryA;
      a_q     <= '0;
      b_q     <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      op_q    <= 1'b0;
      go_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      op_q    <= op_d;
      go_q    <= go_d;
      err_q   <= err_d;
    end
  end

  assign operand_a  = a_q;
  assign operand_b  = b_q;
  assign op         = op_q;
  assign go         = go_q;
  assign err        = err_q;
  assign disp_value = (state_q == StEntryA) ? a_q : b_q;
  assign state_o    = state_q;

endmodule
